// File: rtl/jtag_tunnel_bridge.sv
// jtag_tunnel_bridge: decodes UJTAG user-DR frames into per-target JTAG shifts.
// Define JTAG_TUNNEL_RST_CTRL_EN to add the per-target TRST control register.
module jtag_tunnel_bridge #(
    parameter int         NUM_TGT          = 2,
    parameter logic [7:0] IR_CODE_BASE     = 8'h55,
    parameter int         LEN_W            = 6,
    parameter bit         TRST_ACTIVE_HIGH = 1'b1
) (
    input  logic               TCK,
    input  logic               TRSTB,
    input  logic [7:0]         UIREG,
    input  logic               UDRCAP,
    input  logic               UDRSH,
    input  logic               UDRUPD,
    input  logic               UTDI,
    output logic               UTDO,
    input  logic [NUM_TGT-1:0] TGT_TDO,
    output logic [NUM_TGT-1:0] TGT_TCK_EN,
    output logic [NUM_TGT-1:0] TGT_TMS,
    output logic [NUM_TGT-1:0] TGT_TDI,
    output logic [NUM_TGT-1:0] TGT_TRST,
    output logic               BUSY
);
    localparam int SW = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;
    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);
    localparam logic [LEN_W-1:0] HDR_LAST = LEN_W'(LEN_W);
    localparam logic [NUM_TGT-1:0] TRST_OFF = TRST_ACTIVE_HIGH ? '0 : '1;

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, TRAIL} state_t;

    state_t             state_q;
    logic [SW-1:0]      sel_q;
    logic [LEN_W-1:0]   cnt_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   len_nxt;
    logic               tms_last_q;
    logic [NUM_TGT-1:0] en_q;
    logic [NUM_TGT-1:0] tms_q;
    logic [NUM_TGT-1:0] tdi_q;
    logic [NUM_TGT-1:0] trst_q;
    logic               utdo_q;
    logic               busy_q;

    logic [7:0]         sel_off;
    logic               tgt_ok;
    logic [NUM_TGT-1:0] sel_oh;
    logic               tdo_sel;
    logic               last_bit;

    assign sel_off  = UIREG - IR_CODE_BASE;
    assign tgt_ok   = sel_off < 8'(NUM_TGT);
    assign sel_oh   = NUM_TGT'(1) << sel_q;
    assign tdo_sel  = |(TGT_TDO & sel_oh);
    assign last_bit = cnt_q == (len_q - ONE);

    // Length arrives LSB first, so shift in from the top.
    always_comb begin
        len_nxt = len_q >> 1;
        len_nxt[LEN_W-1] = UTDI;
    end

`ifdef JTAG_TUNNEL_RST_CTRL_EN
    localparam logic [7:0] CTRL_IR = 8'(IR_CODE_BASE + NUM_TGT);

    logic               ctrl_q;
    logic [NUM_TGT-1:0] shreg_q;
    logic [NUM_TGT-1:0] shreg_nxt;

    always_comb begin
        shreg_nxt = shreg_q >> 1;
        shreg_nxt[NUM_TGT-1] = UTDI;
    end
`else
    always_ff @(posedge TCK) begin
        trst_q <= TRSTB ? TRST_OFF : ~TRST_OFF;
    end
`endif

    always_ff @(posedge TCK) begin
        if (!TRSTB) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            tms_last_q <= 1'b0;
            en_q       <= '0;
            tms_q      <= '0;
            tdi_q      <= '0;
            utdo_q     <= 1'b0;
            busy_q     <= 1'b0;
`ifdef JTAG_TUNNEL_RST_CTRL_EN
            ctrl_q     <= 1'b0;
            shreg_q    <= '0;
            trst_q     <= TRST_OFF;
`endif
        end else begin
            en_q   <= '0;
            tms_q  <= '0;
            busy_q <= 1'b0;
            utdo_q <= 1'b0;
            if (UDRUPD) begin
                state_q <= IDLE;
`ifdef JTAG_TUNNEL_RST_CTRL_EN
                if (ctrl_q)
                    trst_q <= shreg_q ^ TRST_OFF;
                ctrl_q <= 1'b0;
`endif
            end else if (UDRCAP) begin
                state_q <= tgt_ok ? HDR : IDLE;
                if (tgt_ok)
                    sel_q <= sel_off[SW-1:0];
                cnt_q <= '0;
                len_q <= '0;
`ifdef JTAG_TUNNEL_RST_CTRL_EN
                ctrl_q  <= UIREG == CTRL_IR;
                shreg_q <= trst_q ^ TRST_OFF;
`endif
            end else if (UDRSH) begin
                unique case (state_q)
                    HDR: begin
                        cnt_q <= cnt_q + ONE;
                        if (cnt_q == '0)
                            tms_last_q <= UTDI;
                        else
                            len_q <= len_nxt;
                        if (cnt_q == HDR_LAST) begin
                            cnt_q   <= '0;
                            state_q <= (len_nxt != '0) ? PAYLOAD : TRAIL;
                        end
                    end
                    PAYLOAD: begin
                        en_q   <= sel_oh;
                        busy_q <= 1'b1;
                        utdo_q <= tdo_sel;
                        tdi_q  <= UTDI ? (tdi_q | sel_oh) : (tdi_q & ~sel_oh);
                        cnt_q  <= cnt_q + ONE;
                        if (last_bit) begin
                            tms_q   <= tms_last_q ? sel_oh : '0;
                            state_q <= TRAIL;
                        end
                    end
                    IDLE: ;
                    TRAIL: ;
                endcase
`ifdef JTAG_TUNNEL_RST_CTRL_EN
                if (ctrl_q) begin
                    shreg_q <= shreg_nxt;
                    utdo_q  <= shreg_q[0];
                end
`endif
            end else if (state_q == PAYLOAD) begin
                // Pause-DR: keep the frame alive without clocking the target.
                busy_q <= cnt_q != '0;
                utdo_q <= utdo_q;
            end
        end
    end

    assign UTDO       = utdo_q;
    assign TGT_TCK_EN = en_q;
    assign TGT_TMS    = tms_q;
    assign TGT_TDI    = tdi_q;
    assign TGT_TRST   = trst_q;
    assign BUSY       = busy_q;

endmodule

// File: tb/tb_jtag_tunnel_bridge.sv
// tb_jtag_tunnel_bridge: scoreboard bench for jtag_tunnel_bridge.
// Honours JTAG_TUNNEL_RST_CTRL_EN for the reset-control checks.
module tb_jtag_tunnel_bridge;
    localparam int NT = 2;
    localparam int LW = 6;
    localparam logic [7:0] BASE = 8'h55;

    logic          TCK = 1'b0;
    logic          TRSTB;
    logic [7:0]    UIREG;
    logic          UDRCAP, UDRSH, UDRUPD, UTDI;
    logic          UTDO;
    logic [NT-1:0] TGT_TDO, TGT_TCK_EN, TGT_TMS, TGT_TDI, TGT_TRST;
    logic          BUSY;

    typedef struct packed {
        logic [7:0] t;
        logic       tdi;
        logic       tms;
        logic       tdo;
    } exp_t;

    exp_t      expq[$];
    exp_t      mon_e;
    bit [63:0] tpat [NT];
    int        tcnt [NT];
    int        tbase [NT];
    int        checks = 0;
    int        errors = 0;
    int        en_cycles = 0;
    bit        mon_on = 0;
    bit        quiet = 0;
    bit        busy_seen = 0;

    always #5 TCK = ~TCK;

    jtag_tunnel_bridge dut (
        .TCK(TCK), .TRSTB(TRSTB), .UIREG(UIREG),
        .UDRCAP(UDRCAP), .UDRSH(UDRSH), .UDRUPD(UDRUPD),
        .UTDI(UTDI), .UTDO(UTDO), .TGT_TDO(TGT_TDO),
        .TGT_TCK_EN(TGT_TCK_EN), .TGT_TMS(TGT_TMS),
        .TGT_TDI(TGT_TDI), .TGT_TRST(TGT_TRST), .BUSY(BUSY)
    );

    // Target model: TDO presents pattern[n] after n gated clocks.
    always_comb begin
        for (int i = 0; i < NT; i++)
            TGT_TDO[i] = tpat[i][6'(tcnt[i] - tbase[i])];
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge TCK) begin
        if (mon_on) begin
            if (TGT_TCK_EN != '0) begin
                en_cycles++;
                if (expq.size() == 0) begin
                    chk("unexpected_en", 64'(TGT_TCK_EN), 64'd0);
                end else begin
                    logic [NT-1:0] oh;
                    mon_e = expq.pop_front();
                    oh = NT'(1) << mon_e.t;
                    chk("en", 64'(TGT_TCK_EN), 64'(oh));
                    chk("tdi", 64'(TGT_TDI[mon_e.t]), 64'(mon_e.tdi));
                    chk("tms", 64'(TGT_TMS), mon_e.tms ? 64'(oh) : 64'd0);
                    chk("utdo", 64'(UTDO), 64'(mon_e.tdo));
                    chk("busy", 64'(BUSY), 64'd1);
                end
            end else begin
                chk("tms_idle", 64'(TGT_TMS), 64'd0);
                if (quiet)
                    chk("utdo_quiet", 64'(UTDO), 64'd0);
            end
            if (BUSY)
                busy_seen = 1;
        end
        for (int i = 0; i < NT; i++)
            if (TGT_TCK_EN[i] === 1'b1)
                tcnt[i]++;
    end

    task automatic cyc(input bit cap, input bit sh, input bit upd, input bit tdi);
        @(posedge TCK);
        #1;
        UDRCAP = cap;
        UDRSH  = sh;
        UDRUPD = upd;
        UTDI   = tdi;
    endtask

    task automatic frame(input logic [7:0] ir, input bit tl, input int len,
                         input bit [63:0] pl, input int extra,
                         input int pause_at, input int abort_at);
        logic [7:0]    d;
        logic [5:0]    lv;
        logic [NT-1:0] tdi0;
        int            t;
        bit            ok;
        int            n_exp;
        exp_t          e;
        d  = ir - BASE;
        t  = int'(d);
        ok = t < NT;
        lv = 6'(len);
        n_exp = !ok ? 0 : (abort_at >= 0 ? abort_at : len);
        for (int i = 0; i < NT; i++)
            tbase[i] = tcnt[i];
        busy_seen = 0;
        en_cycles = 0;
        quiet = !ok;
        tdi0  = TGT_TDI;
        UIREG = ir;
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, tl);
        for (int i = 0; i < LW; i++)
            cyc(0, 1, 0, lv[i]);
        for (int k = 0; k < len; k++) begin
            if (k == abort_at) begin
                cyc(0, 1, 1, pl[k]);
                @(posedge TCK);
                @(negedge TCK);
                chk("abort_en", 64'(TGT_TCK_EN), 64'd0);
                chk("abort_busy", 64'(BUSY), 64'd0);
                break;
            end
            if (k == pause_at) begin
                repeat (3) cyc(0, 0, 0, 0);
                @(negedge TCK);
                chk("pause_en", 64'(TGT_TCK_EN), 64'd0);
                chk("pause_busy", 64'(BUSY), 64'd1);
            end
            if (ok) begin
                e.t   = 8'(t);
                e.tdi = pl[k];
                e.tms = tl && (k == len - 1);
                e.tdo = tpat[t][k];
                expq.push_back(e);
            end
            cyc(0, 1, 0, pl[k]);
        end
        if (abort_at < 0)
            for (int i = 0; i <= extra; i++)
                cyc(0, 1, 0, 1'($urandom));
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        repeat (3) @(posedge TCK);
        @(negedge TCK);
        chk("queue_drained", 64'(expq.size()), 64'd0);
        chk("en_count", 64'(en_cycles), 64'(n_exp));
        chk("busy_after", 64'(BUSY), 64'd0);
        if (!ok)
            chk("tdi_hold", 64'(TGT_TDI), 64'(tdi0));
        if (len == 0)
            chk("l0_busy", 64'(busy_seen), 64'd0);
        expq.delete();
        quiet = 0;
    endtask

    task automatic reset_mid();
        exp_t e;
        bit [63:0] pl;
        logic [5:0] lv;
        pl = {$urandom, $urandom};
        lv = 6'd10;
        for (int i = 0; i < NT; i++)
            tbase[i] = tcnt[i];
        UIREG = BASE;
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 1'b1);
        for (int i = 0; i < LW; i++)
            cyc(0, 1, 0, lv[i]);
        for (int k = 0; k < 3; k++) begin
            e.t = 8'd0;
            e.tdi = pl[k];
            e.tms = 1'b0;
            e.tdo = tpat[0][k];
            expq.push_back(e);
            cyc(0, 1, 0, pl[k]);
        end
        @(posedge TCK);
        #1;
        TRSTB = 1'b0;
        UTDI  = pl[3];
        @(posedge TCK);
        @(negedge TCK);
        chk("rst_mid_en", 64'(TGT_TCK_EN), 64'd0);
        chk("rst_mid_tdi", 64'(TGT_TDI), 64'd0);
        chk("rst_mid_busy", 64'(BUSY), 64'd0);
        chk("rst_mid_utdo", 64'(UTDO), 64'd0);
`ifdef JTAG_TUNNEL_RST_CTRL_EN
        chk("rst_mid_trst", 64'(TGT_TRST), 64'd0);
`else
        chk("rst_mid_trst", 64'(TGT_TRST), 64'd3);
`endif
        chk("rst_mid_queue", 64'(expq.size()), 64'd0);
        cyc(0, 0, 0, 0);
        TRSTB = 1'b1;
        repeat (2) @(posedge TCK);
        @(negedge TCK);
        chk("rst_mid_trst_rel", 64'(TGT_TRST), 64'd0);
        expq.delete();
    endtask

    initial begin
        TRSTB = 1'b0;
        UIREG = 8'h00;
        UDRCAP = 0; UDRSH = 0; UDRUPD = 0; UTDI = 0;
        for (int i = 0; i < NT; i++) begin
            tpat[i]  = '0;
            tbase[i] = 0;
        end
        repeat (3) @(posedge TCK);
        @(negedge TCK);
        chk("rst_en", 64'(TGT_TCK_EN), 64'd0);
        chk("rst_tms", 64'(TGT_TMS), 64'd0);
        chk("rst_tdi", 64'(TGT_TDI), 64'd0);
        chk("rst_utdo", 64'(UTDO), 64'd0);
        chk("rst_busy", 64'(BUSY), 64'd0);
`ifdef JTAG_TUNNEL_RST_CTRL_EN
        chk("rst_trst", 64'(TGT_TRST), 64'd0);
`else
        chk("rst_trst", 64'(TGT_TRST), 64'd3);
`endif
        @(posedge TCK);
        #1;
        TRSTB = 1'b1;
        @(posedge TCK);
        @(negedge TCK);
        chk("rst_trst_rel", 64'(TGT_TRST), 64'd0);
        chk("rst_busy_rel", 64'(BUSY), 64'd0);
        mon_on = 1;

        // Target 1: tms_last=1, L=5, bits 1,0,1,1,0 in send order.
        tpat[1] = {$urandom, $urandom};
        frame(8'h56, 1'b1, 5, 64'b01101, 0, -1, -1);
        // TDO return from target 0: 0,1,1,0.
        tpat[0] = 64'b0110;
        frame(8'h55, 1'b0, 4, {$urandom, $urandom}, 0, -1, -1);
        frame(8'h55, 1'b1, 0, '0, 2, -1, -1);
        frame(8'h40, 1'b1, 5, {$urandom, $urandom}, 0, -1, -1);
        tpat[0] = {$urandom, $urandom};
        frame(8'h55, 1'b1, 8, {$urandom, $urandom}, 0, 3, -1);
        tpat[1] = {$urandom, $urandom};
        frame(8'h56, 1'b1, 8, {$urandom, $urandom}, 0, -1, 2);
        reset_mid();

`ifdef JTAG_TUNNEL_RST_CTRL_EN
        UIREG = 8'h57;
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 1);
        cyc(0, 0, 1, 0);
        @(negedge TCK);
        chk("trst_before_upd", 64'(TGT_TRST), 64'd0);
        @(negedge TCK);
        chk("trst_after_upd", 64'(TGT_TRST), 64'b10);
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        @(negedge TCK);
        chk("ctrl_rd0", 64'(UTDO), 64'd0);
        @(negedge TCK);
        chk("ctrl_rd1", 64'(UTDO), 64'd1);
        cyc(0, 0, 0, 0);
        TRSTB = 1'b0;
        @(posedge TCK);
        @(negedge TCK);
        chk("trst_rst", 64'(TGT_TRST), 64'd0);
        cyc(0, 0, 0, 0);
        TRSTB = 1'b1;
`else
        frame(8'h57, 1'b1, 4, {$urandom, $urandom}, 0, -1, -1);
        chk("ctrl_ir_trst", 64'(TGT_TRST), 64'd0);
`endif

        for (int i = 0; i < 12; i++) begin
            int t, len, pz;
            t   = int'($urandom_range(0, NT - 1));
            len = (i == 0) ? 63 : (i == 1) ? 1 : int'($urandom_range(1, 63));
            pz  = (len > 2 && $urandom_range(0, 2) == 0) ?
                  int'($urandom_range(1, len - 1)) : -1;
            tpat[t] = {$urandom, $urandom};
            frame(BASE + 8'(t), 1'($urandom), len, {$urandom, $urandom},
                  int'($urandom_range(0, 3)), pz, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
